// File: rtl/clock_pkg.sv
// Shared definitions for the clock design: controller states, field limits and packed time.
package clock_pkg;

  localparam int unsigned FIELD_W = 6;

  typedef enum logic [3:0] {
    StIdle      = 4'b0000,
    StRun       = 4'b0001,
    StAlarmSet  = 4'b0010,
    StAlarmRing = 4'b0011,
    StTimeView  = 4'b0100,
    StTimeSet   = 4'b0101
  } ctrl_state_e;

  localparam logic [3:0] TIME_SET = 4'b0101;

  localparam logic [FIELD_W-1:0] HOUR_MAX = 6'd23;
  localparam logic [FIELD_W-1:0] MIN_MAX  = 6'd59;
  localparam logic [FIELD_W-1:0] SEC_MAX  = 6'd59;

  typedef struct packed {
    logic [FIELD_W-1:0] hour;
    logic [FIELD_W-1:0] min;
    logic [FIELD_W-1:0] sec;
  } clock_time_t;

  function automatic logic time_valid(clock_time_t t);
    return (t.hour <= HOUR_MAX) && (t.min <= MIN_MAX) && (t.sec <= SEC_MAX);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-second tick; holds its count while frozen.
module tick_prescaler #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned PRESCALE_W = $clog2(CLK_HZ)
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic freeze,
  input  logic clear,
  output logic tick
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign tick = !freeze && (cnt_q == PRESCALE_W'(CLK_HZ - 1));

  // A valid load restarts the second even when frozen.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (!freeze) begin
      cnt_d = cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_counter.sv
// Time-of-day counter with validated time load; optional alarm compare under
// CLOCK_COUNTER_ALARM_EN.
module clock_counter
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned PRESCALE_W = $clog2(CLK_HZ)
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [3:0]  STATE,
  input  logic [17:0] TIME_SETDATA,
  input  logic        TIME_SET_FLAG,
  output logic [17:0] CLOCK_DATA,
  output logic        SEC_TICK,
  output logic        DAY_ROLL,
  output logic        LOAD_ERR
`ifdef CLOCK_COUNTER_ALARM_EN
  ,
  input  logic [17:0] ALARM_TIME,
  output logic        ALARM
`endif
);

  clock_time_t time_q, time_d, inc_time, load_time;
  logic        flag_prev_q;
  logic        tick, frozen, load_req, load_ok, wrap;
  logic        sec_tick_q, sec_tick_d, day_roll_q, day_roll_d, load_err_q, load_err_d;

  assign frozen    = (STATE == TIME_SET);
  assign load_time = clock_time_t'(TIME_SETDATA);
  assign load_req  = TIME_SET_FLAG && !flag_prev_q;
  assign load_ok   = load_req && time_valid(load_time);

  tick_prescaler #(
    .CLK_HZ     (CLK_HZ),
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .CLK    (CLK),
    .RESETN (RESETN),
    .freeze (frozen),
    .clear  (load_ok),
    .tick   (tick)
  );

  always_comb begin
    inc_time = time_q;
    wrap     = 1'b0;
    if (time_q.sec == SEC_MAX) begin
      inc_time.sec = '0;
      if (time_q.min == MIN_MAX) begin
        inc_time.min = '0;
        if (time_q.hour == HOUR_MAX) begin
          inc_time.hour = '0;
          wrap          = 1'b1;
        end else begin
          inc_time.hour = time_q.hour + 6'd1;
        end
      end else begin
        inc_time.min = time_q.min + 6'd1;
      end
    end else begin
      inc_time.sec = time_q.sec + 6'd1;
    end
  end

  // Any load request, accepted or not, suppresses a coincident tick.
  always_comb begin
    time_d     = time_q;
    sec_tick_d = 1'b0;
    day_roll_d = 1'b0;
    load_err_d = 1'b0;
    if (load_req) begin
      if (load_ok) begin
        time_d = load_time;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick) begin
      time_d     = inc_time;
      sec_tick_d = 1'b1;
      day_roll_d = wrap;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      time_q      <= '0;
      flag_prev_q <= 1'b0;
      sec_tick_q  <= 1'b0;
      day_roll_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      time_q      <= time_d;
      flag_prev_q <= TIME_SET_FLAG;
      sec_tick_q  <= sec_tick_d;
      day_roll_q  <= day_roll_d;
      load_err_q  <= load_err_d;
    end
  end

  assign CLOCK_DATA = time_q;
  assign SEC_TICK   = sec_tick_q;
  assign DAY_ROLL   = day_roll_q;
  assign LOAD_ERR   = load_err_q;

`ifdef CLOCK_COUNTER_ALARM_EN
  logic alarm_q, alarm_d;

  assign alarm_d = sec_tick_d && (inc_time == clock_time_t'(ALARM_TIME));

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign ALARM = alarm_q;
`endif

endmodule

// File: tb/tb_clock_counter.sv
// Self-checking bench for clock_counter: directed scenarios plus random traffic against a
// seconds-of-day reference model.
module tb_clock_counter;

  localparam int unsigned HZ  = 4;
  localparam int unsigned DAY = 86400;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  state;
  logic [17:0] setdata;
  logic        flag;
  logic [17:0] clock_data;
  logic        sec_tick, day_roll, load_err;
  logic [17:0] alarm_time;
`ifdef CLOCK_COUNTER_ALARM_EN
  logic        alarm;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: time as seconds since midnight, prescaler as cycles into the second.
  int unsigned m_tod, m_pre;
  bit          m_prev, m_tick, m_roll, m_err, m_alarm;

  always #5 clk = ~clk;

  clock_counter #(
    .CLK_HZ (HZ)
  ) dut (
    .CLK           (clk),
    .RESETN        (resetn),
    .STATE         (state),
    .TIME_SETDATA  (setdata),
    .TIME_SET_FLAG (flag),
    .CLOCK_DATA    (clock_data),
    .SEC_TICK      (sec_tick),
    .DAY_ROLL      (day_roll),
    .LOAD_ERR      (load_err)
`ifdef CLOCK_COUNTER_ALARM_EN
    ,
    .ALARM_TIME    (alarm_time),
    .ALARM         (alarm)
`endif
  );

  function automatic logic [17:0] pack(int unsigned tod);
    logic [5:0] h, m, s;
    h = 6'(tod / 3600);
    m = 6'((tod / 60) % 60);
    s = 6'(tod % 60);
    return {h, m, s};
  endfunction

  function automatic logic [17:0] hms(int unsigned h, int unsigned m, int unsigned s);
    return {6'(h), 6'(m), 6'(s)};
  endfunction

  task automatic model_edge();
    bit          frozen, load_req, tick_ev;
    int unsigned h, m, s;
    m_tick  = 0;
    m_roll  = 0;
    m_err   = 0;
    m_alarm = 0;
    if (!resetn) begin
      m_tod  = 0;
      m_pre  = 0;
      m_prev = 0;
      return;
    end
    frozen   = (state == 4'b0101);
    load_req = flag && !m_prev;
    tick_ev  = !frozen && (m_pre == HZ - 1);
    h = setdata[17:12];
    m = setdata[11:6];
    s = setdata[5:0];
    if (load_req) begin
      if (h < 24 && m < 60 && s < 60) begin
        m_tod = h * 3600 + m * 60 + s;
        m_pre = 0;
      end else begin
        m_err = 1;
        if (tick_ev) m_pre = 0;
        else if (!frozen) m_pre = m_pre + 1;
      end
    end else begin
      if (tick_ev) begin
        m_tod   = (m_tod + 1) % DAY;
        m_tick  = 1;
        m_roll  = (m_tod == 0);
        m_alarm = (pack(m_tod) == alarm_time);
      end
      if (!frozen) m_pre = tick_ev ? 0 : m_pre + 1;
    end
    m_prev = flag;
  endtask

  task automatic chk(string tag, logic [17:0] got, logic [17:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("clock_data", clock_data, pack(m_tod));
    chk("sec_tick", 18'(sec_tick), 18'(m_tick));
    chk("day_roll", 18'(day_roll), 18'(m_roll));
    chk("load_err", 18'(load_err), 18'(m_err));
`ifdef CLOCK_COUNTER_ALARM_EN
    chk("alarm", 18'(alarm), 18'(m_alarm));
`endif
  endtask

  initial begin
    int          n, cnt, errs;
    logic [17:0] held;
    bit          seen;

    resetn     = 1'b0;
    state      = 4'd1;
    setdata    = '0;
    flag       = 1'b0;
    alarm_time = hms(0, 0, 3);

    // Reset, then free run from 00:00:00.
    cycle();
    cycle();
    resetn = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    chk("run_3s", clock_data, hms(0, 0, 3));

    // Load 23:59:58 and cross midnight.
    setdata = hms(23, 59, 58);
    flag    = 1'b1;
    cycle();
    chk("load_2359", clock_data, hms(23, 59, 58));
    flag = 1'b0;
    n    = 0;
    for (int i = 0; i < 4 * HZ; i++) begin
      cycle();
      if (sec_tick) begin
        n++;
        if (n == 1) chk("tick_235959", clock_data, hms(23, 59, 59));
        if (n == 2) begin
          chk("wrap_data", clock_data, 18'd0);
          chk("wrap_roll", 18'(day_roll), 18'd1);
          break;
        end
      end
    end
    chk("wrap_ticks", 18'(n), 18'd2);
    cycle();
    chk("roll_one_cycle", 18'(day_roll), 18'd0);

    // Freeze mid-second.
    cycle();
    state = 4'b0101;
    held  = clock_data;
    seen  = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (sec_tick) seen = 1;
      if (clock_data !== held) seen = 1;
    end
    chk("freeze_hold", 18'(seen), 18'd0);
    state = 4'd1;
    cnt   = 0;
    n     = int'(HZ - m_pre);
    seen  = 0;
    for (int i = 0; i < 3 * HZ; i++) begin
      cycle();
      cnt++;
      if (sec_tick) begin
        seen = 1;
        break;
      end
    end
    chk("unfreeze_gap", 18'(cnt), 18'(n));
    chk("unfreeze_seen", 18'(seen), 18'd1);

    // Invalid load 24:00:00, flag held high.
    setdata = hms(24, 0, 0);
    flag    = 1'b1;
    held    = clock_data;
    cycle();
    chk("bad_load_time", clock_data, sec_tick ? pack(m_tod) : held);
    errs = int'(load_err);
    for (int i = 0; i < 6; i++) begin
      cycle();
      errs += int'(load_err);
    end
    chk("bad_load_once", 18'(errs), 18'd1);
    flag = 1'b0;
    cycle();

    // Load coincident with the terminal prescaler count.
    for (int i = 0; i < 2 * HZ; i++) begin
      if (m_pre == HZ - 1) break;
      cycle();
    end
    chk("at_terminal", 18'(m_pre), 18'(HZ - 1));
    setdata = hms(12, 34, 56);
    flag    = 1'b1;
    cycle();
    chk("collide_data", clock_data, hms(12, 34, 56));
    chk("collide_notick", 18'(sec_tick), 18'd0);
    flag = 1'b0;
    cnt  = 0;
    for (int i = 0; i < 3 * HZ; i++) begin
      cycle();
      cnt++;
      if (sec_tick) break;
    end
    chk("collide_gap", 18'(cnt), 18'(HZ));
    chk("collide_next", clock_data, hms(12, 34, 57));

`ifdef CLOCK_COUNTER_ALARM_EN
    // Alarm from reset, then a direct load of the alarm time.
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    n = 0;
    for (int i = 0; i < 6 * HZ; i++) begin
      cycle();
      if (alarm) begin
        n++;
        chk("alarm_at", clock_data, hms(0, 0, 3));
      end
    end
    chk("alarm_once", 18'(n), 18'd1);
    setdata = hms(0, 0, 3);
    flag    = 1'b1;
    cycle();
    chk("alarm_no_load", 18'(alarm), 18'd0);
    flag = 1'b0;
    cycle();
`endif

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) resetn = 1'b0;
      else resetn = 1'b1;
      if ($urandom_range(0, 19) == 0) state = (state == 4'b0101) ? 4'($urandom_range(0, 4)) : 4'b0101;
      if ($urandom_range(0, 5) == 0) flag = ~flag;
      if ($urandom_range(0, 3) == 0) begin
        setdata = hms($urandom_range(22, 25), $urandom_range(57, 63), $urandom_range(55, 63));
      end else begin
        setdata = hms($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      end
      if ($urandom_range(0, 49) == 0) alarm_time = pack(m_tod + 1);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
